// File: rtl/sftb_pkg.sv
// Shared types and constants for the stereo I2S receiver.
// Word justification helper lives here so both channels use one definition.
package sftb_pkg;

    localparam int SAMPLE_W = 32;
    localparam int MAX_CNT  = 33;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // A word of n bits sits in the low n bits; move its MSB up to bit 31.
    function automatic logic [SAMPLE_W-1:0] justify(
        input logic [SAMPLE_W-1:0] sh,
        input logic [5:0]          n
    );
        logic [5:0] pad;
        pad = (n >= 6'(SAMPLE_W)) ? 6'd0 : 6'(SAMPLE_W) - n;
        return sh << pad;
    endfunction

endpackage

// File: rtl/stereo_input_i2s_sync.sv
// Two-flop synchronizer for bclk/lrclk/sdata plus a bclk rising-edge detector.
// Bit order inside the synchronizer: [2]=bclk, [1]=lrclk, [0]=sdata.
module i2s_sync (
    input  logic clock,
    input  logic reset,
    input  logic i_bclk,
    input  logic i_lrclk,
    input  logic i_sdata,
    output logic o_lrclk,
    output logic o_sdata,
    output logic o_bclk_rise
);

    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic       r_bprev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1    <= 3'b000;
            r_s2    <= 3'b000;
            r_bprev <= 1'b0;
        end else begin
            r_s1    <= {i_bclk, i_lrclk, i_sdata};
            r_s2    <= r_s1;
            r_bprev <= r_s2[2];
        end
    end

    assign o_lrclk     = r_s2[1];
    assign o_sdata     = r_s2[0];
    assign o_bclk_rise = r_s2[2] & ~r_bprev;

endmodule

// File: rtl/stereo_input.sv
// I2S stereo receiver: aligns on a right-to-left word boundary, delivers L/R pairs.
// Optional STEREO_INPUT_MONO_MIX_EN adds a registered mono = (audio1 + audio2) >>> 1.
module stereo_input
    import sftb_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       bclk,
    input  logic                       lrclk,
    input  logic                       sdata,
    output logic signed [SAMPLE_W-1:0] audio1,
    output logic signed [SAMPLE_W-1:0] audio2,
    output logic                       sample_valid,
    output logic                       frame_error
`ifdef STEREO_INPUT_MONO_MIX_EN
    ,
    output logic signed [SAMPLE_W-1:0] mono
`endif
);

    localparam logic [5:0] W_CNT    = 6'(WIDTH);
    localparam logic [5:0] CNT_FULL = 6'(SAMPLE_W);
    localparam logic [5:0] CNT_SAT  = 6'(MAX_CNT);

    logic                w_lr;
    logic                w_sd;
    logic                w_rise;
    logic                r_lr1;
    logic                r_lr2;
    logic                w_bound;
    logic                w_to_left;
    logic                w_to_right;
    logic [5:0]          r_cnt;
    logic [SAMPLE_W-1:0] r_shift;
    logic [SAMPLE_W-1:0] r_left;
    logic [SAMPLE_W-1:0] w_word;
    logic                w_load_left;
    logic                w_load_pair;
    logic                w_err;
    state_t              r_state;
    state_t              w_next;

    i2s_sync u_sync (
        .clock       (clock),
        .reset       (reset),
        .i_bclk      (bclk),
        .i_lrclk     (lrclk),
        .i_sdata     (sdata),
        .o_lrclk     (w_lr),
        .o_sdata     (w_sd),
        .o_bclk_rise (w_rise)
    );

    // r_lr1/r_lr2 hold lrclk from the previous two bclk rises (I2S one-bit delay).
    assign w_bound    = r_lr1 ^ r_lr2;
    assign w_to_left  = r_lr2 & ~r_lr1;
    assign w_to_right = ~r_lr2 & r_lr1;
    assign w_word     = justify(r_shift, r_cnt);
    assign w_err      = (w_load_left | w_load_pair) & (r_cnt != W_CNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ALIGN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_rise && w_bound) begin
            unique case (r_state)
                ALIGN:   if (w_to_left)  w_next = LEFT;
                LEFT:    if (w_to_right) w_next = RIGHT;
                RIGHT:   if (w_to_left)  w_next = LEFT;
                default: w_next = ALIGN;
            endcase
        end
    end

    always_comb begin
        w_load_left = 1'b0;
        w_load_pair = 1'b0;
        if (w_rise && w_bound) begin
            unique case (r_state)
                LEFT:    w_load_left = 1'b1;
                RIGHT:   w_load_pair = w_to_left;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lr1        <= 1'b0;
            r_lr2        <= 1'b0;
            r_cnt        <= 6'd0;
            r_shift      <= '0;
            r_left       <= '0;
            audio1       <= '0;
            audio2       <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            sample_valid <= w_load_pair;
            frame_error  <= w_err;
            if (w_rise) begin
                r_lr2 <= r_lr1;
                r_lr1 <= w_lr;
                if (w_bound) begin
                    r_cnt   <= 6'd1;
                    r_shift <= {{(SAMPLE_W-1){1'b0}}, w_sd};
                end else begin
                    // Bits past the 32nd are dropped; the count keeps going to 33.
                    if (r_cnt < CNT_FULL) begin
                        r_shift <= {r_shift[SAMPLE_W-2:0], w_sd};
                    end
                    if (r_cnt < CNT_SAT) begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
            end
            if (w_load_left) begin
                r_left <= w_word;
            end
            if (w_load_pair) begin
                audio1 <= r_left;
                audio2 <= w_word;
            end
        end
    end

`ifdef STEREO_INPUT_MONO_MIX_EN
    logic signed [SAMPLE_W:0] w_sum;

    assign w_sum = $signed({r_left[SAMPLE_W-1], r_left})
                 + $signed({w_word[SAMPLE_W-1], w_word});

    always_ff @(posedge clock) begin
        if (reset) begin
            mono <= '0;
        end else if (w_load_pair) begin
            mono <= w_sum[SAMPLE_W:1];
        end
    end
`endif

endmodule

// File: doc/stereo_input.md
STEREO_INPUT -- requirements
Module: stereo_input

Interface
REQ-001 Parameter WIDTH, default 24: number of serial bits captured per channel word, legal 8..32.
REQ-002 clock  input  1  system clock; all logic on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 bclk  input  1  I2S bit clock, asynchronous; requires at least 4 clock periods per bclk period.
REQ-005 lrclk  input  1  I2S word select; 0 = left (audio1), 1 = right (audio2).
REQ-006 sdata  input  1  I2S serial data, MSB first.
REQ-007 audio1  output  32 signed  last complete left sample.
REQ-008 audio2  output  32 signed  last complete right sample.
REQ-009 sample_valid  output  1  one-clock pulse when audio1/audio2 update together.
REQ-010 frame_error  output  1  one-clock pulse when a word ends with a bit count other than WIDTH.

Function
REQ-011 bclk, lrclk and sdata SHALL each pass through a 2-flop synchronizer; bclk rise = synchronized bclk 1 now, 0 on the previous cycle.
REQ-012 On each bclk rise, sdata and lrclk SHALL be sampled together; a bit at rise k belongs to the channel of the lrclk sampled at rise k-1 (I2S one-bit delay).
REQ-013 When the lrclk sampled at rise k-1 differs from the one at rise k-2, the bit at rise k SHALL be the MSB of a new word, and the bit counter SHALL restart at 1.
REQ-014 States: ALIGN (after reset, discard bits), LEFT, RIGHT; ALIGN->LEFT at the first 1->0 word boundary, LEFT->RIGHT at the 0->1 boundary, RIGHT->LEFT at the 1->0 boundary.
REQ-015 Bits beyond 32 in one word SHALL be discarded; the counter SHALL saturate at 33.
REQ-016 A finished word of n bits SHALL be left-justified into 32 bits: bit MSB at [31], the remaining low bits zero; the value is two's complement signed.
REQ-017 The left word SHALL be held internally; audio1 and audio2 SHALL both load on the clock after the right word ends (RIGHT->LEFT boundary), and sample_valid SHALL pulse in that same cycle.
REQ-018 Latency: sample_valid SHALL assert 1 clock after the bclk rise that detects the right-to-left boundary.
REQ-019 If a finished word has n != WIDTH, frame_error SHALL pulse with the boundary; the word is still delivered per REQ-016.
REQ-020 A left word followed directly by another left word (no right word) SHALL NOT produce sample_valid; the newer left word replaces the older one.
REQ-021 audio1/audio2 SHALL hold their values between sample_valid pulses.

Reset
REQ-022 While reset is high: audio1 = 0, audio2 = 0, sample_valid = 0, frame_error = 0, state = ALIGN, counter = 0, shift register = 0, synchronizers = 0.
REQ-023 Reset asserted mid-word SHALL discard the partial frame; the next output SHALL come only after a full left+right pair following a new alignment.

Configuration
REQ-024 Macro STEREO_INPUT_MONO_MIX_EN: when defined, add output mono (32-bit signed) = (audio1 + audio2) >>> 1 computed at 33 bits, registered with sample_valid, reset 0; when undefined, no mono port and no adder logic.

Structure
REQ-025 Shared package sftb_pkg SHALL hold the state enum (ALIGN/LEFT/RIGHT), the constant SAMPLE_W = 32, and the constant MAX_CNT = 33.
REQ-026 Sub-module i2s_sync (3-bit 2-flop synchronizer plus bclk rise detector) SHALL be instantiated once.

Verification
REQ-027 WIDTH=24, left 0x123456, right 0xABCDEF -> sample_valid once; audio1 = 0x12345600, audio2 = 0xABCDEF00 (negative).
REQ-028 Stream begins mid-right-word -> the partial words are discarded and the first sample_valid follows the first complete left+right pair.
REQ-029 WIDTH=24, right word has 20 bits -> frame_error pulses; audio2 holds the 20 bits left-justified, with the low 12 bits zero.
REQ-030 36-bit words with WIDTH=32 -> bits 33..36 dropped; frame_error pulses; audio1 holds the top 32 bits.
REQ-031 Reset pulse in the middle of the right word -> outputs 0; no sample_valid until the next full pair.
REQ-032 STEREO_INPUT_MONO_MIX_EN defined, audio1 = 0x7FFFFF00, audio2 = 0x7FFFFF00 -> mono = 0x7FFFFF00 with no overflow; with audio1 = 0x80000000, audio2 = 0 -> mono = 0xC0000000.
